// File: rtl/p3_reg_file.sv
// ---------------------------------------------------------------------------
// p3_reg_file
//
// Purpose:
//   This is the eight-entry register file for the Simple RISC Machine datapath.
//   It has one synchronous write port, fed by the writeback mux, and one
//   combinational read port, which feeds the operand load registers.
//   A synchronous reset clears every register. Reset takes priority over a
//   write that is presented in the same cycle.
//
// Parameters:
//   DATA_WIDTH  width of each register and of the data ports (default 16)
//   ADDR_WIDTH  register index width (default 3)
//   NUM_REGS    register count; must equal 2**ADDR_WIDTH (default 8)
//
// Ports:
//   i_clk        in   1           rising-edge clock
//   i_reset      in   1           synchronous, active-high; clears all registers
//   i_data_in    in   DATA_WIDTH  write data
//   i_writenum   in   ADDR_WIDTH  write register index
//   i_write      in   1           write enable
//   i_readnum    in   ADDR_WIDTH  read register index
//   o_data_out   out  DATA_WIDTH  contents of R[i_readnum]
// ---------------------------------------------------------------------------
module p3_reg_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic [ADDR_WIDTH-1:0] i_writenum,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_readnum,
  output logic [DATA_WIDTH-1:0] o_data_out
);

  logic [DATA_WIDTH-1:0] r_regFile [NUM_REGS];
  logic [NUM_REGS-1:0]   w_writeDec;
  logic [NUM_REGS-1:0]   w_loadEn;
  logic [NUM_REGS-1:0]   w_readDec;
  logic [DATA_WIDTH-1:0] w_readData;

  // This is the one-hot write decoder. Exactly one bit is set for any index,
  // so every code selects a real register. There are no illegal indices.
  always_comb begin
    w_writeDec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_writenum == ADDR_WIDTH'(i)) begin
        w_writeDec[i] = 1'b1;
      end
    end
  end

  // Gating the decoder with the write enable produces the per-register
  // load enables. When the write enable is low, no register loads.
  assign w_loadEn = w_writeDec & {NUM_REGS{i_write}};

  // Each register has its own storage element with a private load enable.
  // Reset is checked first, which gives it priority over a write in the same cycle.
  // R0 is an ordinary register here; it is not hardwired to zero.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_regFile[g] <= '0;
      end else if (w_loadEn[g]) begin
        r_regFile[g] <= i_data_in;
      end
    end
  end

  // This is the one-hot read decoder. It drives the AND-OR mux below.
  always_comb begin
    w_readDec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_readnum == ADDR_WIDTH'(i)) begin
        w_readDec[i] = 1'b1;
      end
    end
  end

  // The one-hot AND-OR mux selects the register chosen by the read decoder.
  // The read path has no register and no write bypass. A register that is
  // being written shows its old value until the clock edge.
  always_comb begin
    w_readData = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_readData = w_readData | (r_regFile[i] & {DATA_WIDTH{w_readDec[i]}});
    end
  end

  assign o_data_out = w_readData;

endmodule

// File: tb/tb_p3_reg_file.sv
// ---------------------------------------------------------------------------
// tb_p3_reg_file
//
// Purpose:
//   This is a directed, self-checking bench for p3_reg_file. It covers the
//   following behaviours:
//     - reset clears the registers
//     - a disabled write has no effect
//     - basic write and read
//     - wrong-index reads
//     - a full sweep of all registers
//     - no write-to-read bypass
//     - reset has priority over write
//     - reset is sampled only at clock edges
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_p3_reg_file;

  logic        i_clk;
  logic        i_reset;
  logic [15:0] i_data_in;
  logic [2:0]  i_writenum;
  logic        i_write;
  logic [2:0]  i_readnum;
  logic [15:0] o_data_out;

  int checkCount;
  int errorCount;

  p3_reg_file #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(3),
    .NUM_REGS  (8)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_data_in  (i_data_in),
    .i_writenum (i_writenum),
    .i_write    (i_write),
    .i_readnum  (i_readnum),
    .o_data_out (o_data_out)
  );

  // Free-running clock: the period is 10 time units, with rising edges at 5, 15, 25, and so on.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // This watchdog stops the run if the directed sequence never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  // Advance past the next rising edge. Inputs are driven, and outputs
  // sampled, 1 time unit after the edge, away from the active edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Drive the write port for a single edge, then drop the write enable.
  task automatic applyStimulus(input logic [2:0] addr, input logic [15:0] data);
    i_writenum = addr;
    i_data_in  = data;
    i_write    = 1'b1;
    tick();
    i_write    = 1'b0;
  endtask

  // Pulse reset over a single edge with the write enable low.
  task automatic doReset();
    i_reset = 1'b1;
    i_write = 1'b0;
    tick();
    i_reset = 1'b0;
  endtask

  // Select a read index, let the combinational path settle, then compare.
  task automatic checkOutput(input string tag, input logic [2:0] idx,
                             input logic [15:0] expected);
    i_readnum = idx;
    #1;
    checkCount++;
    assert (o_data_out === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, o_data_out, expected);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    i_reset    = 1'b1;
    i_data_in  = 16'h0000;
    i_writenum = 3'd0;
    i_write    = 1'b0;
    i_readnum  = 3'd0;

    // Power-up: apply reset before anything else.
    tick();
    i_reset = 1'b0;
    checkOutput("reset_r0", 3'd0, 16'h0000);
    checkOutput("reset_r7", 3'd7, 16'h0000);

    // Write disabled: two edges with the write enable low must leave R0 clear.
    doReset();
    i_data_in  = 16'hA5A5;
    i_writenum = 3'd0;
    i_write    = 1'b0;
    tick();
    tick();
    checkOutput("write_disabled_r0", 3'd0, 16'h0000);

    // Basic write and read.
    doReset();
    applyStimulus(3'd1, 16'h5A5A);
    checkOutput("basic_r1", 3'd1, 16'h5A5A);
    checkOutput("basic_r0", 3'd0, 16'h0000);

    // Wrong read index.
    doReset();
    applyStimulus(3'd2, 16'h1234);
    checkOutput("wrong_idx_r3", 3'd3, 16'h0000);
    checkOutput("wrong_idx_r2", 3'd2, 16'h1234);

    // Full sweep: write back-to-back on consecutive edges with R[i] = 0x1111*(i+1).
    doReset();
    i_write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_writenum = 3'(i);
      i_data_in  = 16'(16'h1111 * (i + 1));
      tick();
    end
    i_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("sweep_r%0d", i), 3'(i), 16'(16'h1111 * (i + 1)));
    end

    // Back-to-back writes to the same register: the last edge wins.
    i_write    = 1'b1;
    i_writenum = 3'd6;
    i_data_in  = 16'h0101;
    tick();
    i_data_in  = 16'h0202;
    tick();
    i_write    = 1'b0;
    checkOutput("last_edge_wins_r6", 3'd6, 16'h0202);
    checkOutput("last_edge_wins_r7", 3'd7, 16'h8888);

    // No bypass: before the edge, the old value shows; after the edge, the new value shows.
    applyStimulus(3'd4, 16'h00FF);
    i_readnum  = 3'd4;
    i_writenum = 3'd4;
    i_data_in  = 16'hBEEF;
    i_write    = 1'b1;
    checkOutput("no_bypass_before", 3'd4, 16'h00FF);
    tick();
    i_write = 1'b0;
    checkOutput("no_bypass_after", 3'd4, 16'hBEEF);

    // A change to the data input between edges, with the write enable low, has no effect.
    i_data_in = 16'hDEAD;
    checkOutput("hold_between_edges", 3'd4, 16'hBEEF);

    // Reset priority. First, reset asserted between edges leaves R5 intact.
    applyStimulus(3'd5, 16'hCAFE);
    i_reset    = 1'b1;
    i_write    = 1'b1;
    i_writenum = 3'd5;
    i_data_in  = 16'h1357;
    checkOutput("reset_midcycle_r5", 3'd5, 16'hCAFE);
    tick();
    i_reset = 1'b0;
    i_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("reset_prio_r%0d", i), 3'(i), 16'h0000);
    end

    // R0 is writable: it is not hardwired to zero.
    applyStimulus(3'd0, 16'hFFFF);
    checkOutput("r0_writable", 3'd0, 16'hFFFF);
    checkOutput("r0_no_alias_r1", 3'd1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/p3_reg_file.md
# p3_reg_file

Eight-entry, 16-bit register file for the Simple RISC Machine datapath. One synchronous write port and one combinational read port. Sits between the datapath writeback mux (`data_in`) and the operand load registers (`data_out`). Register contents are cleared by a synchronous reset.

## Interface
- Clocking: one clock; reset is synchronous and active-high.
- Parameters:
  - `DATA_WIDTH`, 16: width of each register and of the data ports.
  - `ADDR_WIDTH`, 3: register index width.
  - `NUM_REGS`, 8: register count. Must equal 2^`ADDR_WIDTH`.
- Ports:
  - `clk`  in  1: rising-edge clock.
  - `reset`  in  1: synchronous, active-high; clears all registers.
  - `data_in`  in  DATA_WIDTH: write data.
  - `writenum`  in  ADDR_WIDTH: write register index (R0..R7).
  - `write`  in  1: write enable.
  - `readnum`  in  ADDR_WIDTH: read register index.
  - `data_out`  out  DATA_WIDTH: contents of R[`readnum`].

## Operation
- Storage: registers R0..R7, each `DATA_WIDTH` bits. No register is hardwired; R0 is writable like the others.
- Write decode:
  - `writenum` drives a one-hot 3:8 decoder.
  - Each decoder bit is ANDed with `write` to form the per-register load enable.
  - Exactly one register loads when `write`=1. None load when `write`=0.
- Register update on each rising `clk`:
  - If `reset`=1: all registers become 0. Reset has priority over `write`.
  - Else if load enable for Ri=1: Ri takes `data_in`.
  - Else: Ri holds its value.
- Read path:
  - `readnum` drives a one-hot decoder.
  - An 8:1 one-hot mux drives `data_out` = R[`readnum`].
  - Purely combinational; no registers on the read path.
- No write-to-read bypass. Reading the register being written returns the old value until the clock edge, then the new value.
- All `writenum`/`readnum` codes are valid. There are no illegal indices and no error outputs.
- Unknown/X inputs are not required to be handled.

## Timing
- Write latency: `data_in` appears in the target register, and on `data_out` if `readnum` selects it, immediately after the rising edge where `write`=1 is sampled.
- Read latency: zero cycles. `data_out` follows `readnum` and register contents combinationally.
- `write`, `writenum` and `data_in` must be stable around the rising edge. They are sampled only at the edge; changes between edges have no effect.
- Reset:
  - Sampled only at rising edges. Asserting `reset` between edges changes nothing until the next edge.
  - After a reset edge, all registers read 0, so `data_out`=16'h0000 for any `readnum`.
  - Reset mid-sequence discards all previously written data, including a write presented in the same cycle.
- Power-up before the first reset: contents undefined. Benches must apply reset first.
- Back-to-back writes on consecutive cycles to the same or different registers are supported. The last edge wins.

## Test plan
- Write disabled: reset; `data_in`=16'hA5A5, `writenum`=0, `write`=0, clock 2 edges, `readnum`=0 -> `data_out`=16'h0000.
- Basic write/read: reset; `data_in`=16'h5A5A, `writenum`=1, `write`=1 for one edge, then `write`=0; `readnum`=1 -> `data_out`=16'h5A5A. `readnum`=0 -> 16'h0000.
- Wrong read index: reset; write 16'h1234 to R2; `readnum`=3 -> 16'h0000; `readnum`=2 -> 16'h1234.
- Full sweep: write R i = 16'h1111×(i+1) for i=0..7 on consecutive edges. Read each index -> the matching value, with no aliasing between registers.
- No bypass: R4=16'h00FF; set `readnum`=4, `writenum`=4, `data_in`=16'hBEEF, `write`=1 -> 16'h00FF before the edge, 16'hBEEF after.
- Reset priority: R5=16'hCAFE; `reset`=1 with `write`=1, `writenum`=5, `data_in`=16'h1357 for one edge. Read all indices -> 16'h0000. Asserting `reset` between edges leaves R5 unchanged until the edge.
